// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// opcodes, FSM state encoding and datapath select codes.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_TRAP    = 4'd15
   } state_e;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       irwrite;
      logic       iord;
      logic       memwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

   // States that hold a memory access open until mem_ready
   function automatic logic is_mem_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/multicycle_outdec.sv
// Pure state -> control-word table for the multicycle controller.
// Fetch-phase handshake gating is applied by the parent.
module multicycle_outdec
   import mips_pkg::*;
(
   input  state_e s,
   output ctrl_t  cw
);

   always_comb begin
      cw = '0;
      unique case (s)
         S_FETCH: begin
            cw.pcwrite = 1'b1;
            cw.irwrite = 1'b1;
            cw.alusrcb = SRCB_FOUR;
            cw.aluop   = ALU_ADD;
            cw.pcsrc   = PC_ALU;
         end
         S_DECODE: begin
            cw.alusrcb = SRCB_IMMSH;
            cw.aluop   = ALU_ADD;
         end
         S_MEMADR: begin
            cw.alusrca = 1'b1;
            cw.alusrcb = SRCB_IMM;
            cw.aluop   = ALU_ADD;
         end
         S_MEMRD: begin
            cw.iord = 1'b1;
         end
         S_MEMWB: begin
            cw.memtoreg = 1'b1;
            cw.regwrite = 1'b1;
         end
         S_MEMWR: begin
            cw.iord     = 1'b1;
            cw.memwrite = 1'b1;
         end
         S_EXECUTE: begin
            cw.alusrca = 1'b1;
            cw.alusrcb = SRCB_B;
            cw.aluop   = ALU_FUNCT;
         end
         S_ALUWB: begin
            cw.regdst   = 1'b1;
            cw.regwrite = 1'b1;
         end
         S_BRANCH: begin
            cw.alusrca = 1'b1;
            cw.alusrcb = SRCB_B;
            cw.aluop   = ALU_SUB;
            cw.pcsrc   = PC_ALUOUT;
            cw.branch  = 1'b1;
         end
         S_ADDIEX: begin
            cw.alusrca = 1'b1;
            cw.alusrcb = SRCB_IMM;
            cw.aluop   = ALU_ADD;
         end
         S_ADDIWB: begin
            cw.regwrite = 1'b1;
         end
         S_JUMP: begin
            cw.pcsrc   = PC_JUMP;
            cw.pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core, with a memory-stall
// watchdog and illegal-opcode trap.
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
)
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       branch,
   output logic       irwrite,
   output logic       iord,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       trap,
   output logic [3:0] state
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_st;
   logic          stalled;
   logic          timeout;
   logic          fetch_ok;
   ctrl_t         cw;
   logic          unused_zero;

   always_comb begin
      mem_st  = is_mem_state(state_q);
      stalled = mem_st && !mem_ready;
      timeout = (TIMEOUT != 0) && stalled && (cnt_q == CNT_LAST);
      cnt_d   = stalled ? cnt_q + CW'(1) : '0;
      state_d = state_q;
      unique case (state_q)
         S_FETCH:   if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (mem_ready) state_d = S_FETCH;
         S_EXECUTE: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_TRAP;
      endcase
      // A ready on the last allowed cycle still takes the normal exit
      if (timeout) state_d = S_TRAP;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   multicycle_outdec u_outdec (
      .s  (state_q),
      .cw (cw)
   );

   assign fetch_ok = (state_q != S_FETCH) || mem_ready;

   // Write enables are forced low for as long as reset is held
   assign pcwrite  = reset_n & cw.pcwrite & fetch_ok;
   assign irwrite  = reset_n & cw.irwrite & fetch_ok;
   assign branch   = reset_n & cw.branch;
   assign memwrite = reset_n & cw.memwrite;
   assign regwrite = reset_n & cw.regwrite;
   assign iord     = cw.iord;
   assign memtoreg = cw.memtoreg;
   assign regdst   = cw.regdst;
   assign alusrca  = cw.alusrca;
   assign alusrcb  = cw.alusrcb;
   assign pcsrc    = cw.pcsrc;
   assign aluop    = cw.aluop;
   assign trap     = (state_q == S_TRAP);
   assign state    = state_q;

   assign unused_zero = zero;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level
// step-list model, plus directed literal sequences.
module tb_multicycle_ctrl;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] op = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pcwrite, branch, irwrite, iord, memwrite, memtoreg;
   logic       regdst, regwrite, alusrca, trap;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state;

   multicycle_ctrl #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .op        (op),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pcwrite   (pcwrite),
      .branch    (branch),
      .irwrite   (irwrite),
      .iord      (iord),
      .memwrite  (memwrite),
      .memtoreg  (memtoreg),
      .regdst    (regdst),
      .regwrite  (regwrite),
      .alusrca   (alusrca),
      .alusrcb   (alusrcb),
      .pcsrc     (pcsrc),
      .aluop     (aluop),
      .trap      (trap),
      .state     (state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: the instruction is a list of visited states
   int    steps[$];
   int    idx = 0;
   int    m_w = 0;
   bit    m_trap = 0;
   bit    need_new = 1;
   int    sel = 0;
   string trace_s = "";
   string trace_g = "";
   bit    ir_seen = 0;

   function automatic int exp_state();
      return m_trap ? 15 : steps[idx];
   endfunction

   function automatic logic [15:0] exp_word(input int s, input logic mr);
      logic pw, br, ir, io, mw, mt, rd, rw, sa, tr;
      logic [1:0] sb, ps, ao;
      {pw, br, ir, io, mw, mt, rd, rw, sa, sb, ps, ao, tr} = 16'd0;
      case (s)
         0:  begin pw = mr; ir = mr; sb = 2'b01; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  io = 1;
         4:  begin mt = 1; rw = 1; end
         5:  begin io = 1; mw = 1; end
         6:  begin sa = 1; ao = 2'b10; end
         7:  begin rd = 1; rw = 1; end
         8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin ps = 2'b10; pw = 1; end
         15: tr = 1;
         default: ;
      endcase
      return {pw, br, ir, io, mw, mt, rd, rw, sa, sb, ps, ao, tr};
   endfunction

   function automatic void model_step(input logic mr);
      int s;
      if (m_trap) return;
      s = steps[idx];
      if ((s == 0 || s == 3 || s == 5) && !mr) begin
         m_w++;
         if (TO != 0 && m_w == TO) m_trap = 1;
         return;
      end
      m_w = 0;
      idx++;
      if (idx == steps.size()) need_new = 1;
      else if (steps[idx] == 15) m_trap = 1;
   endfunction

   task automatic start_instr(input logic [5:0] o);
      op = o;
      steps.delete();
      steps.push_back(0);
      steps.push_back(1);
      case (o)
         6'b100011: begin steps.push_back(2); steps.push_back(3); steps.push_back(4); end
         6'b101011: begin steps.push_back(2); steps.push_back(5); end
         6'b000000: begin steps.push_back(6); steps.push_back(7); end
         6'b000100: steps.push_back(8);
         6'b001000: begin steps.push_back(9); steps.push_back(10); end
         6'b000010: steps.push_back(11);
         default:   steps.push_back(15);
      endcase
      idx = 0;
      need_new = 0;
      trace_s = "";
      trace_g = "";
   endtask

   task automatic cycle(input logic mr);
      logic [15:0] got, exp;
      logic g;
      int es;
      mem_ready = mr;
      zero = 1'($urandom_range(0, 1));
      #1;
      es  = exp_state();
      exp = exp_word(es, mr);
      got = {pcwrite, branch, irwrite, iord, memwrite, memtoreg, regdst,
             regwrite, alusrca, alusrcb, pcsrc, aluop, trap};
      checks++;
      if (state !== 4'(es)) begin
         errors++;
         $display("FAIL state t=%0t got %0d want %0d", $time, state, es);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL ctrl t=%0t st=%0d got %b want %b", $time, es, got, exp);
      end
      if (irwrite) ir_seen = 1;
      case (sel)
         0:       g = regwrite;
         1:       g = memwrite;
         2:       g = branch;
         3:       g = pcwrite;
         default: g = iord;
      endcase
      trace_s = (trace_s == "") ? $sformatf("%0d", state)
                                : {trace_s, $sformatf(",%0d", state)};
      trace_g = {trace_g, $sformatf("%0b", g)};
      @(posedge clk);
      model_step(mr);
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [5:0] o, input int stall_idx,
                            input int nstall, input int s,
                            input string exp_st, input string exp_sig,
                            input string name);
      int left;
      int guard;
      left  = nstall;
      guard = 0;
      sel   = s;
      start_instr(o);
      while (!need_new && !m_trap && guard < 100) begin
         guard++;
         if (idx == stall_idx && left > 0) begin
            left--;
            cycle(1'b0);
         end else begin
            cycle(1'b1);
         end
      end
      trace_s = {trace_s, $sformatf(",%0d", state)};
      checks++;
      if (trace_s != exp_st) begin
         errors++;
         $display("FAIL %s_seq got %s want %s", name, trace_s, exp_st);
      end
      checks++;
      if (trace_g != exp_sig) begin
         errors++;
         $display("FAIL %s_sig got %s want %s", name, trace_g, exp_sig);
      end
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state !== 4'd0 || trap !== 1'b0 ||
          {pcwrite, irwrite, regwrite, memwrite, branch} !== 5'b0) begin
         errors++;
         $display("FAIL reset_state got st=%0d trap=%b en=%b want 0 0 00000",
                  state, trap, {pcwrite, irwrite, regwrite, memwrite, branch});
      end
      @(negedge clk);
      reset_n  = 1'b1;
      m_trap   = 0;
      m_w      = 0;
      need_new = 1;
   endtask

   initial begin : main
      string es, eg;
      int    tcount;
      logic [5:0] o;
      #3;
      checks++;
      if (state !== 4'd0 || trap !== 1'b0 ||
          {pcwrite, irwrite, regwrite, memwrite, branch} !== 5'b0) begin
         errors++;
         $display("FAIL por_state got st=%0d trap=%b want 0 0", state, trap);
      end
      @(negedge clk);
      reset_n = 1'b1;

      run_instr(6'b000000, -1, 0, 0, "0,1,6,7,0", "0001", "rtype");
      run_instr(6'b100011, 3, 3, 0, "0,1,2,3,3,3,3,4,0", "00000001", "lw");
      run_instr(6'b101011, -1, 0, 1, "0,1,2,5,0", "0001", "sw");
      run_instr(6'b101011, -1, 0, 4, "0,1,2,5,0", "0001", "sw_iord");
      run_instr(6'b000100, -1, 0, 2, "0,1,8,0", "001", "beq");
      run_instr(6'b000010, -1, 0, 3, "0,1,11,0", "101", "j");
      run_instr(6'b001000, -1, 0, 0, "0,1,9,10,0", "0001", "addi");

      // ready arriving on the last watchdog cycle must win
      es = "0,1,2";
      eg = "000";
      repeat (TO) begin
         es = {es, ",3"};
         eg = {eg, "0"};
      end
      es = {es, ",4,0"};
      eg = {eg, "1"};
      run_instr(6'b100011, 3, TO - 1, 0, es, eg, "lw_edge");

      start_instr(6'b111111);
      tcount = 0;
      repeat (21) begin
         cycle(1'b1);
         if (state == 4'd15 && trap) tcount++;
      end
      checks++;
      if (tcount != 20) begin
         errors++;
         $display("FAIL illegal_trap got %0d want 20", tcount);
      end
      do_reset();

      start_instr(6'b000000);
      ir_seen = 0;
      repeat (TO - 1) cycle(1'b0);
      checks++;
      if (state !== 4'd0) begin
         errors++;
         $display("FAIL wd_pre got %0d want 0", state);
      end
      cycle(1'b0);
      checks++;
      if (state !== 4'd15 || trap !== 1'b1) begin
         errors++;
         $display("FAIL wd_trap got %0d want 15", state);
      end
      checks++;
      if (ir_seen) begin
         errors++;
         $display("FAIL wd_irwrite got 1 want 0");
      end
      repeat (3) cycle(1'b1);
      do_reset();

      start_instr(6'b101011);
      repeat (3) cycle(1'b1);
      cycle(1'b0);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 4'd5 || memwrite !== 1'b1) begin
         errors++;
         $display("FAIL memwr_pre got st=%0d mw=%b want 5 1", state, memwrite);
      end
      do_reset();

      for (int n = 0; n < 300; n++) begin
         int  g;
         int  r;
         bit  longst;
         logic mr;
         r = $urandom_range(0, 15);
         case (r)
            0, 1, 2:   o = 6'b000000;
            3, 4, 13:  o = 6'b100011;
            5, 6, 14:  o = 6'b101011;
            7, 8:      o = 6'b000100;
            9, 10:     o = 6'b001000;
            11, 12:    o = 6'b000010;
            default:   o = 6'($urandom_range(0, 63));
         endcase
         longst = ($urandom_range(0, 9) == 0);
         sel = $urandom_range(0, 4);
         start_instr(o);
         g = 0;
         while (!need_new && !m_trap && g < 200) begin
            g++;
            mr = longst ? 1'($urandom_range(0, 19) == 0)
                        : 1'($urandom_range(0, 3) != 0);
            cycle(mr);
         end
         if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL rand_bound instr %0d got no completion want done", n);
         end
         if (m_trap) begin
            repeat (3) cycle(1'($urandom_range(0, 1)));
            do_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
